// File: rtl/am_modulator_pkg.sv
// Shared constants, sample type and the elaboration-time sine table generator
// for the AM modulator.
package am_pkg;

   localparam int SAMPLE_W   = 12;
   localparam int ENV_OFFSET = 2048;
   localparam int MIX_SHIFT  = 12;
   localparam int IDX_SHIFT  = 8;
   localparam int LUT_AMP    = 2047;

   typedef logic signed [SAMPLE_W-1:0] sample_t;

   // round(LUT_AMP * sin(2*pi*(k+0.5)/2^(aw+2))) via a Q30 Taylor series;
   // only ever called with constant arguments to fill the ROM.
   function automatic sample_t lut_entry(input int k, input int aw);
      longint x_q;
      longint term_q;
      longint sum_q;
      longint prod_q;
      x_q    = (64'sd3373259426 * longint'(2 * k + 1)) >>> (aw + 2);
      term_q = x_q;
      sum_q  = x_q;
      for (int n = 1; n <= 9; n++) begin
         term_q = (term_q * x_q) >>> 30;
         term_q = (term_q * x_q) >>> 30;
         term_q = -term_q / longint'((2 * n) * (2 * n + 1));
         sum_q  = sum_q + term_q;
      end
      prod_q = sum_q * longint'(LUT_AMP) + 64'sd536870912;
      return sample_t'(prod_q >>> 30);
   endfunction

endpackage

// File: rtl/am_modulator_sine_lut.sv
// Quarter-wave sine ROM with half-LSB phase offset; folds the full-wave
// phase index into registered sin and cos (one cycle latency).
module am_sine_lut
   import am_pkg::*;
#(
   parameter int LUT_AW = 8
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic [LUT_AW+1:0] phase_idx,
   output sample_t           sin_val,
   output sample_t           cos_val
);

   localparam int DEPTH = 1 << LUT_AW;

   sample_t           rom_s [DEPTH];
   logic [LUT_AW+1:0] cos_idx_s;
   logic [LUT_AW-1:0] sin_addr_s;
   logic [LUT_AW-1:0] cos_addr_s;
   sample_t           sin_next_s;
   sample_t           cos_next_s;

   for (genvar k = 0; k < DEPTH; k++) begin : g_rom
      localparam sample_t ENTRY = lut_entry(k, LUT_AW);
      assign rom_s[k] = ENTRY;
   end

   function automatic sample_t apply_sign(input sample_t mag, input logic neg);
      if (neg) begin
         return -mag;
      end else begin
         return mag;
      end
   endfunction

   // cos is sin advanced by a quarter turn; odd quadrants read the ROM mirrored
   assign cos_idx_s  = phase_idx + {2'b01, {LUT_AW{1'b0}}};
   assign sin_addr_s = phase_idx[LUT_AW] ? ~phase_idx[LUT_AW-1:0] : phase_idx[LUT_AW-1:0];
   assign cos_addr_s = cos_idx_s[LUT_AW] ? ~cos_idx_s[LUT_AW-1:0] : cos_idx_s[LUT_AW-1:0];
   assign sin_next_s = apply_sign(rom_s[sin_addr_s], phase_idx[LUT_AW+1]);
   assign cos_next_s = apply_sign(rom_s[cos_addr_s], cos_idx_s[LUT_AW+1]);

   // Output register for the folded sin/cos pair
   always_ff @(posedge clk) begin
      if (rst) begin
         sin_val <= 12'sd0;
         cos_val <= 12'sd0;
      end else begin
         sin_val <= sin_next_s;
         cos_val <= cos_next_s;
      end
   end

endmodule

// File: rtl/am_modulator.sv
// AM modulator: envelope 2048 + audio*m mixed onto an NCO quadrature carrier,
// producing 12-bit I/Q through a 3-stage pipeline.
module am_modulator
   import am_pkg::*;
#(
   parameter int PHASE_W = 32,
   parameter int LUT_AW  = 8
)
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic signed [SAMPLE_W-1:0] audio_in,
   input  logic                       audio_valid,
   input  logic [7:0]                 mod_index,
   input  logic [PHASE_W-1:0]         phase_inc,
   output logic signed [SAMPLE_W-1:0] rf_i,
   output logic signed [SAMPLE_W-1:0] rf_q,
   output logic                       out_valid
);

   logic [PHASE_W-1:0] phase_acc_r;
   sample_t            audio_r;
   logic [11:0]        env_r;
   logic [1:0]         fill_cnt_r;
   sample_t            sin_s;
   sample_t            cos_s;
   logic signed [20:0] audio_prod_s;
   logic [11:0]        env_next_s;
   logic signed [24:0] env_wide_s;
   logic signed [24:0] mix_i_s;
   logic signed [24:0] mix_q_s;

   am_sine_lut #(
      .LUT_AW    (LUT_AW)
   ) u_lut (
      .clk       (clk),
      .rst       (rst),
      .phase_idx (phase_acc_r[PHASE_W-1 -: LUT_AW+2]),
      .sin_val   (sin_s),
      .cos_val   (cos_s)
   );

   // Envelope spans [8, 4087], so the sum always fits 12 bits unsigned
   assign audio_prod_s = 21'(audio_r) * 21'($signed({1'b0, mod_index}));
   assign env_next_s   = 12'(13'(ENV_OFFSET) + 13'(audio_prod_s >>> IDX_SHIFT));
   assign env_wide_s   = 25'($signed({1'b0, env_r}));
   assign mix_i_s      = env_wide_s * 25'(cos_s);
   assign mix_q_s      = env_wide_s * 25'(sin_s);

   // NCO, audio capture, envelope, mixer and fill-tracking registers
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_acc_r <= {PHASE_W{1'b0}};
         audio_r     <= 12'sd0;
         env_r       <= 12'd2048;
         rf_i        <= 12'sd0;
         rf_q        <= 12'sd0;
         fill_cnt_r  <= 2'd0;
         out_valid   <= 1'b0;
      end else begin
         phase_acc_r <= phase_acc_r + phase_inc;
         if (audio_valid) begin
            audio_r <= audio_in;
         end
         env_r <= env_next_s;
         rf_i  <= sample_t'(mix_i_s >>> MIX_SHIFT);
         rf_q  <= sample_t'(mix_q_s >>> MIX_SHIFT);
         if (fill_cnt_r != 2'd3) begin
            fill_cnt_r <= fill_cnt_r + 2'd1;
         end
         if (fill_cnt_r == 2'd2) begin
            out_valid <= 1'b1;
         end
      end
   end

endmodule
